sbox6_iter_scheduler: RTL and testbench

- Shares one combinational 6-bit power-map S-box (y = x^34 over GF(2^6), built on the GF((2^2)^3) tower datapath) among N requesters.
- Each request carries a 6-bit operand and an iteration count k. The block applies the S-box k times, one application per cycle, then returns the result with the requester ID.
- Sits between round-function clients (key schedule, state lanes) and the single S-box instance, so that only one S-box is needed in area-constrained builds.

---
 rtl/sbox6_iter_scheduler.sv | 155 +++++++++++++++
 tb/tb_sbox6_iter_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox6_iter_scheduler.sv
// Round-robin scheduler sharing one GF(2^6) x^34 power-map S-box among N requesters;
// each accepted request gets the S-box applied k times, one application per cycle.
module sbox6_iter_scheduler #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int ITW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [6*N-1:0]   req_data,
  input  logic [ITW*N-1:0] req_iter,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [5:0]       rsp_data,
  output logic [IDW-1:0]   rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Tower field: GF(4) = GF(2)[w]/(w^2+w+1), GF(64) = GF(4)[z]/(z^3+w).
  // Byte layout {a2,a1,a0} with a2 in bits [5:4] holding the z^2 coefficient.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] p;
    p[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    p[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return p;
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf4_mulw(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [1:0] c0, c1, c2;
    c0 = gf4_mul(a[1:0], b[1:0])
       ^ gf4_mulw(gf4_mul(a[3:2], b[5:4]) ^ gf4_mul(a[5:4], b[3:2]));
    c1 = gf4_mul(a[1:0], b[3:2]) ^ gf4_mul(a[3:2], b[1:0])
       ^ gf4_mulw(gf4_mul(a[5:4], b[5:4]));
    c2 = gf4_mul(a[1:0], b[5:4]) ^ gf4_mul(a[3:2], b[3:2]) ^ gf4_mul(a[5:4], b[1:0]);
    return {c2, c1, c0};
  endfunction

  function automatic logic [5:0] gf64_sq(input logic [5:0] a);
    return {gf4_sq(a[3:2]), gf4_mulw(gf4_sq(a[5:4])), gf4_sq(a[1:0])};
  endfunction

  // x^34 = x^32 * x^2, five Frobenius squarings plus one multiply.
  function automatic logic [5:0] sbox(input logic [5:0] x);
    logic [5:0] x2, x4, x8, x16, x32;
    x2  = gf64_sq(x);
    x4  = gf64_sq(x2);
    x8  = gf64_sq(x4);
    x16 = gf64_sq(x8);
    x32 = gf64_sq(x16);
    return gf64_mul(x32, x2);
  endfunction

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [5:0]       r_acc;
  logic [ITW-1:0]   r_cnt;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_cand;
  logic [5:0]       w_op;
  logic [ITW-1:0]   w_k;
  logic [5:0]       w_sbox;

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int unsigned j = 1; j <= N; j++) begin
      w_cand = IDW'((r_ptr + j) % N);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Gated by rst so no acceptance strobe is visible while reset is held.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_found && !rst)
      req_ready[w_grant] = 1'b1;
  end

  assign w_op   = req_data[6*w_grant +: 6];
  assign w_k    = req_iter[ITW*w_grant +: ITW];
  assign w_sbox = sbox(r_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(N - 1);
      r_id        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_acc  <= w_op;
            r_cnt  <= w_k;
            r_id   <= w_grant;
            r_ptr  <= w_grant;
            r_busy <= 1'b1;
            if (w_k == '0) begin
              r_state     <= DONE;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= w_sbox;
          r_cnt <= r_cnt - ITW'(1);
          if (r_cnt == ITW'(1)) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_acc;
  assign rsp_id    = r_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sbox6_iter_scheduler.sv
// Directed bench for sbox6_iter_scheduler: reset, pass-through, sweeps, round-robin,
// backpressure and pointer priority, checked against a log-table GF(2^6) model.
module tb_sbox6_iter_scheduler;
  localparam int N = 4, IDW = 2, ITW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [6*N-1:0]   req_data;
  logic [ITW*N-1:0] req_iter;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [5:0]       rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_ready;
  logic             busy;

  int errors = 0;
  int checks = 0;

  sbox6_iter_scheduler #(.N(N), .IDW(IDW), .ITW(ITW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_iter(req_iter), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // GF(4) via discrete logs: 1=w^0 (01), w=w^1 (10), w^2=w+1 (11).
  function automatic int lg4(input logic [1:0] a);
    case (a)
      2'b01:   return 0;
      2'b10:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] ex4(input int e);
    case (e)
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return ex4((lg4(a) + lg4(b)) % 3);
  endfunction

  // GF(64) = GF(4)[z]/(z^3 + w): schoolbook product then fold z^3 -> w, z^4 -> w*z.
  function automatic logic [5:0] m64(input logic [5:0] a, input logic [5:0] b);
    logic [1:0] p [5];
    for (int i = 0; i < 5; i++) p[i] = 2'b00;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i+j] = p[i+j] ^ m4(a[2*i +: 2], b[2*j +: 2]);
    p[1] = p[1] ^ m4(2'b10, p[4]);
    p[0] = p[0] ^ m4(2'b10, p[3]);
    return {p[2], p[1], p[0]};
  endfunction

  function automatic logic [5:0] pw34(input logic [5:0] x);
    logic [5:0] r;
    r = 6'h01;
    repeat (34) r = m64(r, x);
    return r;
  endfunction

  function automatic logic [5:0] sbox_n(input logic [5:0] x, input int n);
    logic [5:0] r;
    r = x;
    repeat (n) r = pw34(r);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int maxc, output logic [N-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    #1;
    for (int c = 0; c < maxc && !ok; c++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        g  = req_ready;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  // Raise one request, hold until accepted, drop it just after the transfer edge.
  task automatic send(input int i, input logic [5:0] d, input logic [ITW-1:0] k,
                      output bit ok);
    logic [N-1:0] g;
    req_data[6*i +: 6]     = d;
    req_iter[ITW*i +: ITW] = k;
    req_valid[i]           = 1'b1;
    wait_grant(64, g, ok);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    while (!ok && lat < maxc) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_hold got v=%b d=%h id=%0d busy=%b rdy=%b exp all zero",
               rsp_valid, rsp_data, rsp_id, busy, req_ready);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_release got v=%b d=%h id=%0d busy=%b rdy=%b exp all zero",
               rsp_valid, rsp_data, rsp_id, busy, req_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, quiet;
    int lat;
    logic [N-1:0] g;
    send(2, 6'h2D, 4'd9, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrun_grant got timeout exp grant"); end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", busy); end
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got v=%b d=%h id=%0d busy=%b rdy=%b exp all zero",
               rsp_valid, rsp_data, rsp_id, busy, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL midrun_quiet got rsp/busy activity exp none"); end
    req_data[0 +: 6]         = 6'h11;
    req_iter[0 +: ITW]       = 4'd0;
    req_data[18 +: 6]        = 6'h22;
    req_iter[3*ITW +: ITW]   = 4'd0;
    req_valid = 4'b1001;
    wait_grant(20, g, ok);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("FAIL midrun_next_grant got %b exp 0001", g);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(10, lat, ok);
    checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_data !== 6'h11) begin
      errors++;
      $display("FAIL midrun_rsp got ok=%b id=%0d d=%h exp id=0 d=11", ok, rsp_id, rsp_data);
    end
    ack();
  endtask

  task automatic test_passthrough();
    bit ok;
    int lat;
    logic [N-1:0] g;
    req_data[6 +: 6]       = 6'h2B;
    req_iter[ITW +: ITW]   = 4'd0;
    req_valid[1]           = 1'b1;
    wait_grant(20, g, ok);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL pass_ready got %b exp 0010", g); end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp(10, lat, ok);
    checks++;
    if (!ok || lat != 1) begin errors++; $display("FAIL pass_latency got %0d exp 1", lat); end
    checks++;
    if (rsp_data !== 6'h2B || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL pass_data got d=%h id=%0d exp d=2b id=1", rsp_data, rsp_id);
    end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL pass_ready_done got %b exp 0000", req_ready); end
    ack();
  endtask

  task automatic test_sweep();
    bit ok;
    int lat;
    logic [5:0] x;
    logic [ITW-1:0] kz [3];
    kz[0] = 4'd3; kz[1] = 4'd7; kz[2] = 4'd15;
    for (int v = 0; v < 64; v++) begin
      x = 6'(v);
      send(0, x, 4'd6, ok);
      wait_rsp(20, lat, ok);
      checks++;
      if (!ok || lat != 7 || rsp_data !== x || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL sweep_k6 x=%h got lat=%0d d=%h id=%0d exp lat=7 d=%h id=0",
                 x, lat, rsp_data, rsp_id, x);
      end
      ack();
    end
    for (int v = 0; v < 64; v++) begin
      x = 6'(v);
      send(0, x, 4'd1, ok);
      wait_rsp(20, lat, ok);
      checks++;
      if (!ok || lat != 2 || rsp_data !== pw34(x)) begin
        errors++;
        $display("FAIL sweep_k1 x=%h got lat=%0d d=%h exp lat=2 d=%h",
                 x, lat, rsp_data, pw34(x));
      end
      ack();
    end
    for (int i = 0; i < 3; i++) begin
      send(0, 6'h00, kz[i], ok);
      wait_rsp(30, lat, ok);
      checks++;
      if (!ok || rsp_data !== 6'h00) begin
        errors++;
        $display("FAIL zero_operand k=%0d got d=%h exp 00", kz[i], rsp_data);
      end
      ack();
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] ops [4];
    logic [N-1:0] one;
    int exp_g, cur, nrsp, t_gr, cyc;
    ops[0] = 6'h05; ops[1] = 6'h1A; ops[2] = 6'h33; ops[3] = 6'h3E;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_data[6*i +: 6]     = ops[i];
      req_iter[ITW*i +: ITW] = 4'd2;
    end
    exp_g = 0; cur = 0; nrsp = 0; t_gr = 0; cyc = 0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    while (nrsp < 8 && cyc < 200) begin
      #1;
      if (req_ready != '0) begin
        one = 4'b0001 << exp_g;
        checks++;
        if (req_ready !== one) begin
          errors++;
          $display("FAIL rr_grant got %b exp %b", req_ready, one);
        end
        t_gr  = cyc;
        cur   = exp_g;
        exp_g = (exp_g + 1) % 4;
      end
      if (rsp_valid) begin
        checks++;
        if (cyc - t_gr != 3 || rsp_id !== 2'(cur) || rsp_data !== sbox_n(ops[cur], 2)) begin
          errors++;
          $display("FAIL rr_rsp got lat=%0d id=%0d d=%h exp lat=3 id=%0d d=%h",
                   cyc - t_gr, rsp_id, rsp_data, cur, sbox_n(ops[cur], 2));
        end
        nrsp++;
        if (nrsp == 8) req_valid = '0;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (nrsp != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", nrsp); end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    int lat;
    logic [5:0] exp_d;
    exp_d = sbox_n(6'h15, 3);
    send(3, 6'h15, 4'd15, ok);
    wait_rsp(40, lat, ok);
    checks++;
    if (!ok || lat != 16) begin errors++; $display("FAIL bp_latency got %0d exp 16", lat); end
    req_data[0 +: 6]   = 6'h01;
    req_iter[0 +: ITW] = 4'd1;
    req_valid[0]       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      stable = (rsp_valid === 1'b1) && (rsp_data === exp_d) && (rsp_id === 2'd3)
            && (busy === 1'b1) && (req_ready === '0);
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b d=%h id=%0d busy=%b rdy=%b exp v=1 d=%h id=3 busy=1 rdy=0000",
                 c, rsp_valid, rsp_data, rsp_id, busy, req_ready, exp_d);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    ack();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_ptr_priority();
    bit ok;
    int lat;
    logic [N-1:0] g;
    do_reset();
    send(0, 6'h07, 4'd0, ok);
    wait_rsp(10, lat, ok);
    ack();
    req_data[0 +: 6]       = 6'h09;
    req_iter[0 +: ITW]     = 4'd1;
    req_data[12 +: 6]      = 6'h24;
    req_iter[2*ITW +: ITW] = 4'd1;
    req_valid = 4'b0101;
    wait_grant(20, g, ok);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL ptr_first got %b exp 0100", g); end
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_rsp(10, lat, ok);
    checks++;
    if (!ok || rsp_id !== 2'd2 || rsp_data !== pw34(6'h24)) begin
      errors++;
      $display("FAIL ptr_rsp2 got id=%0d d=%h exp id=2 d=%h", rsp_id, rsp_data, pw34(6'h24));
    end
    ack();
    wait_grant(20, g, ok);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL ptr_second got %b exp 0001", g); end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(10, lat, ok);
    checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_data !== pw34(6'h09)) begin
      errors++;
      $display("FAIL ptr_rsp0 got id=%0d d=%h exp id=0 d=%h", rsp_id, rsp_data, pw34(6'h09));
    end
    ack();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_iter  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_reset_mid_run();
    test_passthrough();
    test_sweep();
    test_round_robin();
    test_backpressure();
    test_ptr_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
